// File: rtl/pi1_arbiter.sv
// Round-robin arbiter sharing one PI1 slave port among MASTERCOUNT PI1 masters,
// with a burst cap and per-master parking of responses drained during handover.
module pi1_arbiter #(
  parameter  int unsigned ARCHBITSZ   = 32,
  parameter  int unsigned MASTERCOUNT = 2,
  parameter  int unsigned MAXBURST    = 8,
  localparam int unsigned SELBITSZ    = ARCHBITSZ / 8,
  localparam int unsigned ADDRBITSZ   = ARCHBITSZ - $clog2(SELBITSZ)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [2*MASTERCOUNT-1:0]         s_pi1_op_i,
  input  logic [ADDRBITSZ*MASTERCOUNT-1:0] s_pi1_addr_i,
  input  logic [ARCHBITSZ*MASTERCOUNT-1:0] s_pi1_data_i,
  output logic [ARCHBITSZ*MASTERCOUNT-1:0] s_pi1_data_o,
  input  logic [SELBITSZ*MASTERCOUNT-1:0]  s_pi1_sel_i,
  output logic [MASTERCOUNT-1:0]           s_pi1_rdy_o,
  output logic [1:0]                       m_pi1_op_o,
  output logic [ADDRBITSZ-1:0]             m_pi1_addr_o,
  output logic [ARCHBITSZ-1:0]             m_pi1_data_o,
  input  logic [ARCHBITSZ-1:0]             m_pi1_data_i,
  output logic [SELBITSZ-1:0]              m_pi1_sel_o,
  input  logic                             m_pi1_rdy_i
);

  localparam int unsigned IDXW = (MASTERCOUNT > 1) ? $clog2(MASTERCOUNT) : 1;
  localparam int unsigned SUMW = IDXW + 1;
  localparam int unsigned CNTW = $clog2(MAXBURST + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] OP_NOOP  = 2'b00;

  logic [1:0]             r_state,    w_state_nxt;
  logic [IDXW-1:0]        r_gnt,      w_gnt_nxt;
  logic [IDXW-1:0]        r_rrptr,    w_rrptr_nxt;
  logic [IDXW-1:0]        r_owner,    w_owner_nxt;
  logic [CNTW-1:0]        r_burstcnt, w_burstcnt_nxt;
  logic                   r_ownvld,   w_ownvld_nxt;
  logic [MASTERCOUNT-1:0] r_holdvld,  w_holdvld_nxt;
  logic [ARCHBITSZ-1:0]   r_hold [MASTERCOUNT];
  logic                   w_hold_we;

  logic [1:0]             w_op   [MASTERCOUNT];
  logic [ADDRBITSZ-1:0]   w_addr [MASTERCOUNT];
  logic [ARCHBITSZ-1:0]   w_wdat [MASTERCOUNT];
  logic [SELBITSZ-1:0]    w_sel  [MASTERCOUNT];
  logic [MASTERCOUNT-1:0] w_req;
  logic [MASTERCOUNT-1:0] w_gnt_mask;
  logic                   w_oth_req;
  logic                   w_cap;
  logic                   w_serve;
  logic [IDXW-1:0]        w_gnt_inc;
  logic [IDXW-1:0]        w_pick;
  logic                   w_pick_vld;
  logic [SUMW-1:0]        w_sum;

  // Per-master unpacking, requests and response steering
  for (genvar m = 0; m < MASTERCOUNT; m++) begin : g_master
    logic w_rdy;
    assign w_op[m]   = s_pi1_op_i[2*m +: 2];
    assign w_addr[m] = s_pi1_addr_i[ADDRBITSZ*m +: ADDRBITSZ];
    assign w_wdat[m] = s_pi1_data_i[ARCHBITSZ*m +: ARCHBITSZ];
    assign w_sel[m]  = s_pi1_sel_i[SELBITSZ*m +: SELBITSZ];
    assign w_req[m]  = (w_op[m] != OP_NOOP) || r_holdvld[m];
    assign w_rdy     = w_serve && (r_gnt == IDXW'(m));
    assign s_pi1_rdy_o[m] = w_rdy;
    assign s_pi1_data_o[ARCHBITSZ*m +: ARCHBITSZ] =
      !w_rdy                                   ? '0 :
      r_holdvld[m]                             ? r_hold[m] :
      (r_ownvld && (r_owner == IDXW'(m)))      ? m_pi1_data_i : '0;
  end

  assign w_gnt_mask = MASTERCOUNT'(1) << r_gnt;
  assign w_oth_req  = |(w_req & ~w_gnt_mask);
  // Cap pre-empts acceptance: the cycle that decides to hand over issues no rdy
  assign w_cap      = (r_state == ST_GRANT) && (r_burstcnt == CNTW'(MAXBURST)) && w_oth_req;
  assign w_serve    = !rst_i && (r_state == ST_GRANT) && !w_cap && m_pi1_rdy_i;
  assign w_gnt_inc  = (r_gnt == IDXW'(MASTERCOUNT - 1)) ? '0 : r_gnt + IDXW'(1);

  assign m_pi1_op_o   = (!rst_i && (r_state == ST_GRANT) && !w_cap) ? w_op[r_gnt] : OP_NOOP;
  assign m_pi1_addr_o = w_addr[r_gnt];
  assign m_pi1_data_o = w_wdat[r_gnt];
  assign m_pi1_sel_o  = w_sel[r_gnt];

  // First requester at or after the round-robin pointer
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_rrptr;
    w_sum      = '0;
    for (int unsigned k = 0; k < MASTERCOUNT; k++) begin
      w_sum = {1'b0, r_rrptr} + SUMW'(k);
      if (w_sum >= SUMW'(MASTERCOUNT)) w_sum = w_sum - SUMW'(MASTERCOUNT);
      if (!w_pick_vld && w_req[w_sum[IDXW-1:0]]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_sum[IDXW-1:0];
      end
    end
  end

  // Next-state logic; a slave stall freezes everything
  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_rrptr_nxt    = r_rrptr;
    w_burstcnt_nxt = r_burstcnt;
    w_ownvld_nxt   = r_ownvld;
    w_owner_nxt    = r_owner;
    w_holdvld_nxt  = r_holdvld;
    w_hold_we      = 1'b0;
    if (m_pi1_rdy_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_pick_vld) begin
            w_state_nxt    = ST_GRANT;
            w_gnt_nxt      = w_pick;
            w_burstcnt_nxt = '0;
          end
        end
        ST_GRANT: begin
          if (w_cap) begin
            w_state_nxt = ST_DRAIN;
          end else begin
            w_holdvld_nxt[r_gnt] = 1'b0;
            if (w_op[r_gnt] != OP_NOOP) begin
              w_ownvld_nxt   = 1'b1;
              w_owner_nxt    = r_gnt;
              w_burstcnt_nxt = (r_burstcnt == CNTW'(MAXBURST)) ? r_burstcnt
                                                               : r_burstcnt + CNTW'(1);
            end else begin
              w_ownvld_nxt = 1'b0;
              w_state_nxt  = ST_IDLE;
              w_rrptr_nxt  = w_gnt_inc;
            end
          end
        end
        ST_DRAIN: begin
          // The accepted NOOP returns the outstanding response; park it for its owner
          if (r_ownvld) begin
            w_hold_we              = 1'b1;
            w_holdvld_nxt[r_owner] = 1'b1;
          end
          w_ownvld_nxt = 1'b0;
          w_rrptr_nxt  = w_gnt_inc;
          w_state_nxt  = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_rrptr    <= '0;
      r_owner    <= '0;
      r_burstcnt <= '0;
      r_ownvld   <= 1'b0;
      r_holdvld  <= '0;
      for (int m = 0; m < int'(MASTERCOUNT); m++) r_hold[m] <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_rrptr    <= w_rrptr_nxt;
      r_owner    <= w_owner_nxt;
      r_burstcnt <= w_burstcnt_nxt;
      r_ownvld   <= w_ownvld_nxt;
      r_holdvld  <= w_holdvld_nxt;
      if (w_hold_we) r_hold[r_owner] <= m_pi1_data_i;
    end
  end

  a_own_consistent: assert property (@(posedge clk_i) disable iff (rst_i)
    r_ownvld |-> ((r_owner == r_gnt) && (r_state != ST_IDLE)));

  a_rdy_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    $onehot0(s_pi1_rdy_o));

endmodule

// File: tb/tb_pi1_arbiter.sv
// Directed bench for pi1_arbiter: two instances (2 masters/MAXBURST=4, 3 masters/MAXBURST=8)
// driven cycle by cycle with hand-computed expected outputs.
module tb_pi1_arbiter;

  localparam logic [1:0] NOOP = 2'b00;
  localparam logic [1:0] WR   = 2'b01;
  localparam logic [1:0] RD   = 2'b10;
  localparam logic [1:0] RW   = 2'b11;

  logic clk;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  a_op;    logic [59:0] a_addr;  logic [63:0] a_wdat;  logic [63:0] a_rdat;
  logic [7:0]  a_sel;   logic [1:0]  a_rdy;   logic [1:0]  a_mop;   logic [29:0] a_maddr;
  logic [31:0] a_mwdat; logic [31:0] a_mrdat; logic [3:0]  a_msel;  logic        a_mrdy;

  logic [5:0]  b_op;    logic [89:0] b_addr;  logic [95:0] b_wdat;  logic [95:0] b_rdat;
  logic [11:0] b_sel;   logic [2:0]  b_rdy;   logic [1:0]  b_mop;   logic [29:0] b_maddr;
  logic [31:0] b_mwdat; logic [31:0] b_mrdat; logic [3:0]  b_msel;  logic        b_mrdy;

  int n_vec;
  int n_bad;

  pi1_arbiter #(.ARCHBITSZ(32), .MASTERCOUNT(2), .MAXBURST(4)) u_dut2 (
    .clk_i(clk), .rst_i(rst),
    .s_pi1_op_i(a_op), .s_pi1_addr_i(a_addr), .s_pi1_data_i(a_wdat), .s_pi1_data_o(a_rdat),
    .s_pi1_sel_i(a_sel), .s_pi1_rdy_o(a_rdy),
    .m_pi1_op_o(a_mop), .m_pi1_addr_o(a_maddr), .m_pi1_data_o(a_mwdat), .m_pi1_data_i(a_mrdat),
    .m_pi1_sel_o(a_msel), .m_pi1_rdy_i(a_mrdy)
  );

  pi1_arbiter #(.ARCHBITSZ(32), .MASTERCOUNT(3), .MAXBURST(8)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .s_pi1_op_i(b_op), .s_pi1_addr_i(b_addr), .s_pi1_data_i(b_wdat), .s_pi1_data_o(b_rdat),
    .s_pi1_sel_i(b_sel), .s_pi1_rdy_o(b_rdy),
    .m_pi1_op_o(b_mop), .m_pi1_addr_o(b_maddr), .m_pi1_data_o(b_mwdat), .m_pi1_data_i(b_mrdat),
    .m_pi1_sel_o(b_msel), .m_pi1_rdy_i(b_mrdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic exp2(input string tag, input logic [1:0] rdy, input logic [1:0] op);
    chk({tag, ".rdy"}, 64'(a_rdy), 64'(rdy));
    chk({tag, ".op"},  64'(a_mop), 64'(op));
  endtask

  task automatic exp3(input string tag, input logic [2:0] rdy, input logic [1:0] op);
    chk({tag, ".rdy"}, 64'(b_rdy), 64'(rdy));
    chk({tag, ".op"},  64'(b_mop), 64'(op));
  endtask

  // One cycle on the 2-master instance: drive after negedge, outputs settled 1ns later
  task automatic step2(input logic [1:0] op0, input logic [29:0] ad0,
                       input logic [1:0] op1, input logic [29:0] ad1,
                       input logic mrdy, input logic [31:0] mrdat);
    @(negedge clk);
    rst     = 1'b0;
    a_op    = {op1, op0};
    a_addr  = {ad1, ad0};
    a_mrdy  = mrdy;
    a_mrdat = mrdat;
    #1;
  endtask

  task automatic step3(input logic [1:0] op0, input logic [1:0] op1, input logic [1:0] op2,
                       input logic mrdy, input logic [31:0] mrdat);
    @(negedge clk);
    rst     = 1'b0;
    b_op    = {op2, op1, op0};
    b_mrdy  = mrdy;
    b_mrdat = mrdat;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst     = 1'b1;
    a_op    = '0;
    b_op    = '0;
    a_mrdy  = 1'b1;
    b_mrdy  = 1'b1;
    a_mrdat = '0;
    b_mrdat = '0;
    #1;
    exp2("rst2", 2'b00, NOOP);
    exp3("rst3", 3'b000, NOOP);
  endtask

  initial begin
    n_vec   = 0;
    n_bad   = 0;
    clk     = 1'b0;
    rst     = 1'b1;
    a_op    = '0;
    a_addr  = '0;
    a_wdat  = {32'hB1B1_B1B1, 32'hA0A0_A0A0};
    a_sel   = 8'hC3;
    a_mrdat = '0;
    a_mrdy  = 1'b1;
    b_op    = '0;
    b_addr  = {30'h2C, 30'h1C, 30'h0C};
    b_wdat  = '0;
    b_sel   = 12'hFFF;
    b_mrdat = '0;
    b_mrdy  = 1'b1;

    // Single master read, response on the following NOOP rdy
    do_reset();
    step2(RD, 30'h10, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s1.idle", 2'b00, NOOP);
    step2(RD, 30'h10, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s1.grant", 2'b01, RD);
    chk("s1.addr", 64'(a_maddr), 64'h10);
    chk("s1.data0a", a_rdat[31:0], 64'h0);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'hDEAD_BEEF);
    exp2("s1.resp", 2'b01, NOOP);
    chk("s1.data0", a_rdat[31:0], 64'hDEAD_BEEF);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s1.idle2", 2'b00, NOOP);

    // Simultaneous reads: master 0 first, then master 1; one stall cycle in GRANT
    do_reset();
    step2(RD, 30'h20, RD, 30'h30, 1'b1, 32'h0);
    exp2("s2.idle", 2'b00, NOOP);
    step2(RD, 30'h20, RD, 30'h30, 1'b0, 32'h0);
    exp2("s2.stall", 2'b00, RD);
    chk("s2.stall.addr", 64'(a_maddr), 64'h20);
    step2(RD, 30'h20, RD, 30'h30, 1'b1, 32'h0);
    exp2("s2.m0", 2'b01, RD);
    chk("s2.m0.wdat", 64'(a_mwdat), 64'hA0A0_A0A0);
    chk("s2.m0.sel", 64'(a_msel), 64'h3);
    step2(NOOP, 30'h0, RD, 30'h30, 1'b1, 32'h1111_1111);
    exp2("s2.m0.resp", 2'b01, NOOP);
    chk("s2.m0.data", a_rdat[31:0], 64'h1111_1111);
    chk("s2.m1.quiet", a_rdat[63:32], 64'h0);
    step2(NOOP, 30'h0, RD, 30'h30, 1'b1, 32'h0);
    exp2("s2.idle2", 2'b00, NOOP);
    step2(NOOP, 30'h0, RD, 30'h30, 1'b1, 32'h0);
    exp2("s2.m1", 2'b10, RD);
    chk("s2.m1.addr", 64'(a_maddr), 64'h30);
    chk("s2.m1.wdat", 64'(a_mwdat), 64'hB1B1_B1B1);
    chk("s2.m1.sel", 64'(a_msel), 64'hC);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h2222_2222);
    exp2("s2.m1.resp", 2'b10, NOOP);
    chk("s2.m1.data", a_rdat[63:32], 64'h2222_2222);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s2.idle3", 2'b00, NOOP);

    // Burst cap (MAXBURST=4): 4th response parked, master 1 served, parked data returned
    do_reset();
    step2(WR, 30'h100, RD, 30'h40, 1'b1, 32'h0);
    exp2("s3.idle", 2'b00, NOOP);
    for (int i = 0; i < 4; i++) begin
      step2(WR, 30'h100 + 30'(i), RD, 30'h40, 1'b1, 32'hA000_0000 + 32'(i));
      exp2($sformatf("s3.wr%0d", i), 2'b01, WR);
      chk($sformatf("s3.wr%0d.data", i), a_rdat[31:0],
          (i == 0) ? 64'h0 : 64'hA000_0000 + 64'(i));
    end
    step2(WR, 30'h104, RD, 30'h40, 1'b1, 32'hA000_0004);
    exp2("s3.cap", 2'b00, NOOP);
    step2(WR, 30'h104, RD, 30'h40, 1'b1, 32'hB0B0_0004);
    exp2("s3.drain", 2'b00, NOOP);
    step2(WR, 30'h104, RD, 30'h40, 1'b1, 32'h0);
    exp2("s3.idle2", 2'b00, NOOP);
    step2(WR, 30'h104, RD, 30'h40, 1'b1, 32'h0);
    exp2("s3.m1", 2'b10, RD);
    chk("s3.m1.addr", 64'(a_maddr), 64'h40);
    chk("s3.m1.data0", a_rdat[63:32], 64'h0);
    step2(WR, 30'h104, NOOP, 30'h0, 1'b1, 32'hC0C0_C0C0);
    exp2("s3.m1.resp", 2'b10, NOOP);
    chk("s3.m1.data", a_rdat[63:32], 64'hC0C0_C0C0);
    chk("s3.m0.quiet", a_rdat[31:0], 64'h0);
    step2(WR, 30'h104, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s3.idle3", 2'b00, NOOP);
    step2(WR, 30'h104, NOOP, 30'h0, 1'b1, 32'hEEEE_EEEE);
    exp2("s3.m0.again", 2'b01, WR);
    chk("s3.parked", a_rdat[31:0], 64'hB0B0_0004);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h1234_5678);
    exp2("s3.m0.last", 2'b01, NOOP);
    chk("s3.m0.lastdata", a_rdat[31:0], 64'h1234_5678);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s3.idle4", 2'b00, NOOP);

    // Slave stalls 5 cycles in DRAIN; capture only when rdy returns
    do_reset();
    step2(WR, 30'h200, RD, 30'h50, 1'b1, 32'h0);
    exp2("s4.idle", 2'b00, NOOP);
    for (int i = 0; i < 4; i++) begin
      step2(WR, 30'h200 + 30'(i), RD, 30'h50, 1'b1, 32'h0);
      exp2($sformatf("s4.wr%0d", i), 2'b01, WR);
    end
    step2(WR, 30'h204, RD, 30'h50, 1'b1, 32'h0);
    exp2("s4.cap", 2'b00, NOOP);
    for (int i = 0; i < 5; i++) begin
      step2(NOOP, 30'h0, NOOP, 30'h0, 1'b0, 32'hBAD0_0000 + 32'(i));
      exp2($sformatf("s4.stall%0d", i), 2'b00, NOOP);
    end
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h600D_600D);
    exp2("s4.capture", 2'b00, NOOP);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s4.idle2", 2'b00, NOOP);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h9999_9999);
    exp2("s4.collect", 2'b01, NOOP);
    chk("s4.parked", a_rdat[31:0], 64'h600D_600D);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s4.idle3", 2'b00, NOOP);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s4.released", 2'b00, NOOP);

    // Reset in the middle of an RW: outstanding op and parked state discarded
    do_reset();
    step2(RW, 30'h300, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s5.idle", 2'b00, NOOP);
    step2(RW, 30'h300, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s5.rw", 2'b01, RW);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp2("s5.inrst", 2'b00, NOOP);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h7777_7777);
    exp2("s5.post", 2'b00, NOOP);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s5.nohold", 2'b00, NOOP);
    step2(RD, 30'h310, NOOP, 30'h0, 1'b1, 32'h0);
    exp2("s5.idle2", 2'b00, NOOP);
    step2(RD, 30'h310, NOOP, 30'h0, 1'b1, 32'h7777_7777);
    exp2("s5.rd", 2'b01, RD);
    chk("s5.noown", a_rdat[31:0], 64'h0);
    step2(NOOP, 30'h0, NOOP, 30'h0, 1'b1, 32'h0000_0005);
    exp2("s5.resp", 2'b01, NOOP);
    chk("s5.data", a_rdat[31:0], 64'h5);

    // Three masters: after master 1 releases, master 2 wins, then wrap to master 0
    do_reset();
    step3(NOOP, RD, NOOP, 1'b1, 32'h0);
    exp3("s6.idle", 3'b000, NOOP);
    step3(NOOP, RD, NOOP, 1'b1, 32'h0);
    exp3("s6.m1", 3'b010, RD);
    chk("s6.m1.addr", 64'(b_maddr), 64'h1C);
    step3(NOOP, NOOP, RD, 1'b1, 32'h0000_00AB);
    exp3("s6.m1.rel", 3'b010, NOOP);
    chk("s6.m1.data", b_rdat[63:32], 64'hAB);
    step3(RD, RD, RD, 1'b1, 32'h0);
    exp3("s6.idle2", 3'b000, NOOP);
    step3(RD, RD, RD, 1'b1, 32'h0);
    exp3("s6.m2", 3'b100, RD);
    chk("s6.m2.addr", 64'(b_maddr), 64'h2C);
    step3(RD, RD, NOOP, 1'b1, 32'h0000_00CD);
    exp3("s6.m2.rel", 3'b100, NOOP);
    chk("s6.m2.data", b_rdat[95:64], 64'hCD);
    step3(RD, RD, NOOP, 1'b1, 32'h0);
    exp3("s6.idle3", 3'b000, NOOP);
    step3(RD, RD, NOOP, 1'b1, 32'h0);
    exp3("s6.m0", 3'b001, RD);
    chk("s6.m0.addr", 64'(b_maddr), 64'h0C);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pi1_arbiter.md
Name: pi1_arbiter

Overview:
- Shares one downstream PI1 slave port among MASTERCOUNT upstream PI1 masters. Typical downstream target is the PI1-to-Wishbone bridge.
- Round-robin grant with a burst cap.
- Preserves PI1 pipelined semantics: the response to an op is returned on the requester's next rdy cycle. A response drained from the slave during a forced handover is parked per master until that master is next served.

Parameters:
ARCHBITSZ, 32, data bus width; must be 16, 32, 64 or 128. Local ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).
MASTERCOUNT, 2, number of upstream masters; must be >= 2.
MAXBURST, 8, max consecutive non-NOOP ops accepted for one master while others request; must be >= 1.

Ports:
clk_i  in  1  clock; all logic on posedge.
rst_i  in  1  reset; synchronous, active-high.
s_pi1_op_i  in  2*MASTERCOUNT  per-master op; master m in bits [2m+1:2m]. 00 NOOP, 01 WR, 10 RD, 11 RW.
s_pi1_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master address.
s_pi1_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
s_pi1_data_o  out  ARCHBITSZ*MASTERCOUNT  per-master read data.
s_pi1_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte select.
s_pi1_rdy_o  out  MASTERCOUNT  per-master ready.
m_pi1_op_o  out  2  op to slave.
m_pi1_addr_o  out  ADDRBITSZ  address to slave.
m_pi1_data_o  out  ARCHBITSZ  write data to slave.
m_pi1_data_i  in  ARCHBITSZ  read data from slave.
m_pi1_sel_o  out  ARCHBITSZ/8  byte select to slave.
m_pi1_rdy_i  in  1  slave ready.

Behaviour:
- Registered state:
  - state: IDLE, GRANT or DRAIN.
  - gnt: granted master index.
  - rrptr: round-robin pointer.
  - burstcnt.
  - ownvld/owner: an op is outstanding at the slave and which master issued it.
  - hold[m] and holdvld[m]: parked response, one per master.
- Request: req[m] = (op[m] != NOOP) || holdvld[m].
- Reset (rst_i high at posedge): state=IDLE, ownvld=0, holdvld=0, burstcnt=0, rrptr=0. While rst_i is high, all s_pi1_rdy_o=0 and m_pi1_op_o=NOOP. Any op in flight at reset is discarded.
- Downstream mux (combinational):
  - In GRANT, m_pi1_op/addr/data/sel = master gnt's inputs.
  - In IDLE and DRAIN, m_pi1_op_o=NOOP; addr/data/sel are don't-care (drive the gnt master's values).
- s_pi1_rdy_o[m] = !rst_i && state==GRANT && gnt==m && m_pi1_rdy_i. Never more than one bit set.
- s_pi1_data_o[m]:
  - When rdy_o[m]=1: hold[m] if holdvld[m]; else m_pi1_data_i if (ownvld && owner==m); else 0.
  - All other times: 0.
- IDLE:
  - If any req, pick the first requester at or after rrptr (cyclic).
  - Next cycle: GRANT, gnt = pick, burstcnt=0.
  - Grant latency: 1 cycle from req to first possible rdy.
- GRANT, cycle where rdy_o[gnt]=1:
  - Clear holdvld[gnt].
  - If op[gnt] != NOOP: ownvld=1, owner=gnt, burstcnt++.
  - If op[gnt] == NOOP: ownvld=0, state -> IDLE, rrptr = gnt+1 (mod MASTERCOUNT).
- GRANT, cap: if burstcnt==MAXBURST and any other req[j] (j != gnt), state -> DRAIN on the next edge.
  - Evaluated every GRANT cycle; takes priority over accepting further ops. No rdy is issued in the transition cycle.
- DRAIN:
  - Wait for m_pi1_rdy_i=1 (the NOOP is then accepted).
  - If ownvld: hold[owner] <= m_pi1_data_i, holdvld[owner] <= 1.
  - Then ownvld=0, rrptr = gnt+1, state -> IDLE.
  - If ownvld=0, DRAIN exits on the first cycle m_pi1_rdy_i=1 without capture.
- Invariants:
  - ownvld implies owner==gnt, and state is GRANT or DRAIN.
  - holdvld[gnt] is never set while ownvld && owner==gnt.
- A master holding NOOP with holdvld set is granted solely to collect its parked data. It gets one rdy cycle, then the arbiter releases.
- Slave stall (m_pi1_rdy_i=0) in any state: no state change, no rdy to masters.
- burstcnt saturates at MAXBURST.

Test Plan:
- Single master 0: RD addr 0x10 held until rdy, then NOOP; slave returns 0xDEADBEEF on the next rdy. Required: rdy_o[0] one cycle after req; data_o[0]=0xDEADBEEF on the NOOP rdy cycle; arbiter back in IDLE.
- Both masters issue RD simultaneously from reset. Required: master 0 served first (rrptr=0), then master 1; both receive correct data; no cycle has both rdy bits set.
- MAXBURST=4: master 0 streams 10 WRs while master 1 requests a RD. Required: after 4 accepted WRs a NOOP is drained; master 0's 4th response is parked; master 1 gets its RD; master 0's next rdy returns the parked data.
- Slave holds m_pi1_rdy_i=0 for 5 cycles during DRAIN. Required: no master rdy; capture happens only on the cycle rdy returns.
- rst_i asserted mid-RW op. Required: next cycle all rdy_o=0, m_pi1_op_o=NOOP, all holdvld=0.
- MASTERCOUNT=3: masters 1 and 2 request while master 1 is being released. Required: master 2 is granted next, not master 1 (round-robin fairness).
